// File: rtl/cim_job_if.sv
// Host/DMA and system_io signals seen by the CIM job sequencer.
// master is the sequencer's view; slave is the surrounding host plus macro.
interface cim_job_if;
  logic        start;
  logic [8:0]  cfg_wlen;
  logic [4:0]  cfg_olen;
  logic        cfg_act;
  logic [15:0] x_data;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        wen;
  logic        wbuf;
  logic        cal;
  logic        cal_done;
  logic [8:0]  a_chip;
  logic [15:0] d;
  logic        eact;
  logic [5:0]  q;
  logic        r_valid;
  logic        r_ready;
  logic [5:0]  r_data;
  logic        r_last;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, cfg_wlen, cfg_olen, cfg_act, x_data, w_valid, w_data, cal_done, q, r_ready,
    output w_ready, wen, wbuf, cal, a_chip, d, eact, r_valid, r_data, r_last, busy, done, err
  );

  modport slave (
    output start, cfg_wlen, cfg_olen, cfg_act, x_data, w_valid, w_data, cal_done, q, r_ready,
    input  w_ready, wen, wbuf, cal, a_chip, d, eact, r_valid, r_data, r_last, busy, done, err
  );
endinterface

// File: rtl/cim_job_sequencer.sv
// Runs one CIM job on system_io: weight load, input-buffer write, calculate, result readback.
// Every output is a register; each state's strobes are set on the transition into it.
module cim_job_sequencer #(
  parameter int unsigned CAL_TIMEOUT = 1023,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  cim_job_if.master  bus
);

  localparam int unsigned TmoW = $clog2(CAL_TIMEOUT + 1);
  localparam int unsigned LatW = 2;

  typedef enum logic [2:0] {
    StIdle, StLoad, StBuf, StCal, StWait, StRead, StOut
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  wlen_q, wlen_d;
  logic [4:0]  olen_q, olen_d;
  logic [15:0] x_q, x_d;
  logic [8:0]  idx_q, idx_d;
  logic [4:0]  oidx_q, oidx_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [LatW-1:0] lat_q, lat_d;

  logic        w_ready_q, w_ready_d;
  logic        wen_q, wen_d;
  logic        wbuf_q, wbuf_d;
  logic        cal_q, cal_d;
  logic [8:0]  a_chip_q, a_chip_d;
  logic [15:0] d_q, d_d;
  logic        eact_q, eact_d;
  logic        r_valid_q, r_valid_d;
  logic [5:0]  r_data_q, r_data_d;
  logic        r_last_q, r_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    wlen_d    = wlen_q;
    olen_d    = olen_q;
    x_d       = x_q;
    idx_d     = idx_q;
    oidx_d    = oidx_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    w_ready_d = w_ready_q;
    a_chip_d  = a_chip_q;
    d_d       = d_q;
    eact_d    = eact_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_last_d  = r_last_q;
    busy_d    = busy_q;
    wen_d     = 1'b0;
    wbuf_d    = 1'b0;
    cal_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          wlen_d = bus.cfg_wlen;
          olen_d = bus.cfg_olen;
          x_d    = bus.x_data;
          eact_d = bus.cfg_act;
          busy_d = 1'b1;
          idx_d  = '0;
          if (bus.cfg_wlen != 9'd0) begin
            state_d   = StLoad;
            w_ready_d = 1'b1;
          end else begin
            state_d  = StBuf;
            wbuf_d   = 1'b1;
            d_d      = bus.x_data;
            a_chip_d = '0;
          end
        end
      end

      StLoad: begin
        // idx == wlen only in the cycle carrying the final wen; BUF follows it directly.
        if (idx_q == wlen_q) begin
          state_d  = StBuf;
          wbuf_d   = 1'b1;
          d_d      = x_q;
          a_chip_d = '0;
        end else if (bus.w_valid && w_ready_q) begin
          wen_d    = 1'b1;
          d_d      = bus.w_data;
          a_chip_d = idx_q;
          idx_d    = idx_q + 9'd1;
          if (idx_q == wlen_q - 9'd1) begin
            w_ready_d = 1'b0;
          end
        end
      end

      StBuf: begin
        state_d = StCal;
        cal_d   = 1'b1;
      end

      StCal: begin
        state_d = StWait;
        tmo_d   = '0;
      end

      StWait: begin
        if (bus.cal_done) begin
          state_d  = StRead;
          oidx_d   = '0;
          lat_d    = '0;
          a_chip_d = '0;
        end else if (tmo_q == TmoW'(CAL_TIMEOUT - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          eact_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StRead: begin
        // a_chip was set on entry, so q is valid READ_LAT cycles into this state.
        if (lat_q == LatW'(READ_LAT)) begin
          state_d   = StOut;
          r_valid_d = 1'b1;
          r_data_d  = bus.q;
          r_last_d  = (oidx_q == olen_q);
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      StOut: begin
        if (bus.r_ready) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          if (r_last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            eact_d  = 1'b0;
          end else begin
            state_d  = StRead;
            oidx_d   = oidx_q + 5'd1;
            lat_d    = '0;
            a_chip_d = {4'b0, oidx_q + 5'd1};
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wlen_q    <= '0;
      olen_q    <= '0;
      x_q       <= '0;
      idx_q     <= '0;
      oidx_q    <= '0;
      tmo_q     <= '0;
      lat_q     <= '0;
      w_ready_q <= 1'b0;
      wen_q     <= 1'b0;
      wbuf_q    <= 1'b0;
      cal_q     <= 1'b0;
      a_chip_q  <= '0;
      d_q       <= '0;
      eact_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wlen_q    <= wlen_d;
      olen_q    <= olen_d;
      x_q       <= x_d;
      idx_q     <= idx_d;
      oidx_q    <= oidx_d;
      tmo_q     <= tmo_d;
      lat_q     <= lat_d;
      w_ready_q <= w_ready_d;
      wen_q     <= wen_d;
      wbuf_q    <= wbuf_d;
      cal_q     <= cal_d;
      a_chip_q  <= a_chip_d;
      d_q       <= d_d;
      eact_q    <= eact_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_last_q  <= r_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.w_ready = w_ready_q;
  assign bus.wen     = wen_q;
  assign bus.wbuf    = wbuf_q;
  assign bus.cal     = cal_q;
  assign bus.a_chip  = a_chip_q;
  assign bus.d       = d_q;
  assign bus.eact    = eact_q;
  assign bus.r_valid = r_valid_q;
  assign bus.r_data  = r_data_q;
  assign bus.r_last  = r_last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_cim_job_sequencer.sv
// Directed bench for cim_job_sequencer; system_io q is modelled as a one-cycle registered read.
module tb_cim_job_sequencer;
  localparam int CalTimeout = 1023;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic       q_mode;
  logic [5:0] q_const;

  cim_job_if bus ();

  cim_job_sequencer #(
    .CAL_TIMEOUT(CalTimeout),
    .READ_LAT   (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // READ_LAT=1 macro: q follows the address one clock later.
  always @(posedge clk) bus.q <= q_mode ? ({1'b0, bus.a_chip[4:0]} + 6'd10) : q_const;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.cfg_wlen = 0; bus.cfg_olen = 0; bus.cfg_act = 0; bus.x_data = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.cal_done = 0; bus.r_ready = 0;
    q_mode = 0; q_const = 0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.r_valid) bus.cal_done = 0;
      if (bus.done) begin
        seen = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    step(); step();
    checks++;
    if ({bus.w_ready, bus.wen, bus.wbuf, bus.cal, bus.eact, bus.r_valid, bus.r_last,
         bus.busy, bus.done, bus.err} !== 10'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.w_ready, bus.wen, bus.wbuf, bus.cal,
               bus.eact, bus.r_valid, bus.r_last, bus.busy, bus.done, bus.err});
    end
    checks++;
    if ({bus.a_chip, bus.d, bus.r_data} !== 31'd0) begin
      failures++;
      $display("FAIL reset_data: a_chip=%h d=%h r_data=%h want 0", bus.a_chip, bus.d, bus.r_data);
    end
    rst = 0;
    step(); step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_load();
    logic [15:0] words [3];
    int k = 0, n_wen = 0, first = -1, last = -1, wbuf_cnt = 0, wbuf_cyc = -1;
    int cal_cnt = 0, cal_cyc = -1, overlap = 0;
    bit seen;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    bus.cfg_wlen = 3; bus.cfg_olen = 0; bus.cfg_act = 1; bus.x_data = 16'hABCD;
    bus.w_valid = 1; bus.w_data = words[0]; bus.start = 1;
    step();
    bus.start = 0; bus.x_data = 16'h5555; bus.cfg_act = 0;
    checks++;
    if ({bus.busy, bus.eact, bus.w_ready} !== 3'b111) begin
      failures++;
      $display("FAIL load_entry: busy/eact/w_ready got %b want 111",
               {bus.busy, bus.eact, bus.w_ready});
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus.wen) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if (n_wen > 2 || bus.a_chip !== 9'(n_wen) || bus.d !== words[n_wen]) begin
          failures++;
          $display("FAIL load_wen%0d: a_chip=%0d d=%h want a_chip=%0d d=%h", n_wen, bus.a_chip,
                   bus.d, n_wen, (n_wen < 3) ? words[n_wen] : 16'h0);
        end
        n_wen++;
      end
      if (bus.wbuf) begin
        wbuf_cnt++;
        wbuf_cyc = cyc;
        checks++;
        if (bus.d !== 16'hABCD || bus.a_chip !== 9'd0) begin
          failures++;
          $display("FAIL load_wbuf: d=%h a_chip=%0d want d=abcd a_chip=0", bus.d, bus.a_chip);
        end
      end
      if (bus.cal) begin
        cal_cnt++;
        cal_cyc = cyc;
      end
      if (int'(bus.wen) + int'(bus.wbuf) + int'(bus.cal) > 1) overlap++;
      bus.w_data = (k < 3) ? words[k] : 16'hDEAD;
      if (bus.w_ready) k++;
      step();
    end
    bus.w_valid = 0;
    checks++;
    if (n_wen != 3 || k != 3 || first != 1 || last != 3) begin
      failures++;
      $display("FAIL load_count: wen=%0d hs=%0d first=%0d last=%0d want 3 3 1 3", n_wen, k,
               first, last);
    end
    checks++;
    if (wbuf_cnt != 1 || wbuf_cyc != 4 || cal_cnt != 1 || cal_cyc != 5 || overlap != 0) begin
      failures++;
      $display("FAIL load_seq: wbuf=%0d@%0d cal=%0d@%0d overlap=%0d want 1@4 1@5 0", wbuf_cnt,
               wbuf_cyc, cal_cnt, cal_cyc, overlap);
    end
    bus.cal_done = 1; bus.r_ready = 1;
    wait_done(20, seen);
    checks++;
    if (!seen || bus.busy !== 1'b0 || bus.eact !== 1'b0) begin
      failures++;
      $display("FAIL load_finish: done=%0d busy=%b eact=%b want 1 0 0", seen, bus.busy, bus.eact);
    end
    bus.cal_done = 0; bus.r_ready = 0;
    step();
  endtask

  task automatic test_single();
    int cal_at = -1, done_cyc = -1, wen_cnt = 0, res_cnt = 0, done_cnt = 0;
    logic [5:0] got_data = 0;
    logic got_last = 0, busy_at_done = 1, busy_next = 1;
    bus.cfg_wlen = 0; bus.cfg_olen = 0; bus.x_data = 16'h0001;
    q_const = 6'd42; bus.r_ready = 1; bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (bus.cal) cal_at = cyc;
      if (cal_at >= 0 && cyc == cal_at + 5) bus.cal_done = 1;
      if (bus.wen) wen_cnt++;
      if (bus.r_valid && bus.r_ready) begin
        res_cnt++;
        got_data = bus.r_data;
        got_last = bus.r_last;
        bus.cal_done = 0;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = bus.busy;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_next = bus.busy;
      step();
    end
    checks++;
    if (wen_cnt != 0 || res_cnt != 1) begin
      failures++;
      $display("FAIL single_counts: wen=%0d results=%0d want 0 1", wen_cnt, res_cnt);
    end
    checks++;
    if (got_data !== 6'd42 || got_last !== 1'b1) begin
      failures++;
      $display("FAIL single_result: data=%0d last=%b want 42 1", got_data, got_last);
    end
    checks++;
    if (done_cnt != 1 || busy_at_done !== 1'b0 || busy_next !== 1'b0) begin
      failures++;
      $display("FAIL single_done: done=%0d busy@done=%b busy+1=%b want 1 0 0", done_cnt,
               busy_at_done, busy_next);
    end
  endtask

  task automatic test_stall();
    int n = 0, done_cnt = 0;
    bit held = 0;
    logic [5:0] hold_data = 0;
    logic hold_last = 0;
    bus.cfg_wlen = 0; bus.cfg_olen = 3; q_mode = 1; bus.r_ready = 0; bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus.cal) bus.cal_done = 1;
      bus.r_ready = (cyc % 2 == 0);
      if (bus.r_valid) begin
        bus.cal_done = 0;
        if (held) begin
          checks++;
          if (bus.r_data !== hold_data || bus.r_last !== hold_last) begin
            failures++;
            $display("FAIL stall_hold: data=%0d last=%b want %0d %b", bus.r_data, bus.r_last,
                     hold_data, hold_last);
          end
        end
        if (bus.r_ready) begin
          checks++;
          if (bus.r_data !== 6'(10 + n) || bus.r_last !== (n == 3)) begin
            failures++;
            $display("FAIL stall_res%0d: data=%0d last=%b want %0d %b", n, bus.r_data,
                     bus.r_last, 10 + n, (n == 3));
          end
          n++;
          held = 0;
        end else begin
          held = 1;
          hold_data = bus.r_data;
          hold_last = bus.r_last;
        end
      end else begin
        held = 0;
      end
      if (bus.done) done_cnt++;
      step();
    end
    checks++;
    if (n != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL stall_count: results=%0d done=%0d want 4 1", n, done_cnt);
    end
    q_mode = 0; bus.r_ready = 0;
  endtask

  task automatic test_timeout();
    int cal_at = -1, err_at = -1, err_cnt = 0, done_cnt = 0, res_cnt = 0;
    logic busy_err = 1;
    logic [5:0] res_data = 0;
    bus.cfg_wlen = 0; bus.cfg_olen = 0; bus.cal_done = 0; bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (bus.cal && cal_at < 0) cal_at = cyc;
      if (bus.err) begin
        err_cnt++;
        err_at = cyc;
        busy_err = bus.busy;
      end
      if (bus.done) done_cnt++;
      step();
    end
    checks++;
    if (err_cnt != 1 || err_at - cal_at != CalTimeout + 1) begin
      failures++;
      $display("FAIL timeout_err: pulses=%0d delay=%0d want 1 %0d", err_cnt, err_at - cal_at,
               CalTimeout + 1);
    end
    checks++;
    if (done_cnt != 0 || busy_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: done=%0d busy@err=%b busy=%b want 0 0 0", done_cnt, busy_err,
               bus.busy);
    end
    q_const = 6'd7; bus.r_ready = 1; done_cnt = 0; bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.cal) bus.cal_done = 1;
      if (bus.r_valid && bus.r_ready) begin
        res_cnt++;
        res_data = bus.r_data;
        bus.cal_done = 0;
      end
      if (bus.done) done_cnt++;
      step();
    end
    checks++;
    if (res_cnt != 1 || res_data !== 6'd7 || done_cnt != 1) begin
      failures++;
      $display("FAIL timeout_rerun: results=%0d data=%0d done=%0d want 1 7 1", res_cnt,
               res_data, done_cnt);
    end
    bus.r_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] words [5];
    int k = 0, n = 0, first_wen = 0;
    bit seen;
    for (int i = 0; i < 5; i++) words[i] = 16'hA000 + 16'(i);
    bus.cfg_wlen = 5; bus.cfg_olen = 0; bus.cfg_act = 1; bus.w_valid = 1;
    bus.w_data = words[0]; bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bus.wen) n++;
      if (n == 2) break;
      bus.w_data = words[k];
      if (bus.w_ready) k++;
      step();
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL rstmid_reach: wen=%0d want 2", n);
    end
    rst = 1; bus.w_valid = 0;
    step();
    rst = 0;
    checks++;
    if ({bus.w_ready, bus.wen, bus.wbuf, bus.cal, bus.eact, bus.r_valid, bus.r_last,
         bus.busy, bus.done, bus.err} !== 10'd0 || bus.a_chip !== 9'd0 || bus.d !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_outs: ctrl=%b a_chip=%0d d=%h want 0", {bus.w_ready, bus.wen,
               bus.wbuf, bus.cal, bus.eact, bus.r_valid, bus.r_last, bus.busy, bus.done,
               bus.err}, bus.a_chip, bus.d);
    end
    words[0] = 16'h7777; words[1] = 16'h8888;
    k = 0;
    bus.cfg_wlen = 2; bus.w_valid = 1; bus.w_data = words[0]; bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.wen && !first_wen) begin
        first_wen = 1;
        checks++;
        if (bus.a_chip !== 9'd0 || bus.d !== 16'h7777) begin
          failures++;
          $display("FAIL rstmid_restart: a_chip=%0d d=%h want 0 7777", bus.a_chip, bus.d);
        end
      end
      bus.w_data = (k < 2) ? words[k] : 16'hDEAD;
      if (bus.w_ready) k++;
      step();
    end
    bus.w_valid = 0; bus.cal_done = 1; bus.r_ready = 1;
    wait_done(20, seen);
    checks++;
    if (!first_wen || !seen) begin
      failures++;
      $display("FAIL rstmid_finish: wen_seen=%0d done=%0d want 1 1", first_wen, seen);
    end
    bus.cal_done = 0; bus.r_ready = 0;
    step();
  endtask

  task automatic test_start_in_wait();
    int cal_at = -1, rv_at = -1, wen_cnt = 0, res_cnt = 0, done_cnt = 0;
    bus.cfg_wlen = 0; bus.cfg_olen = 0; q_const = 6'd33; bus.cal_done = 0; bus.r_ready = 1;
    bus.start = 1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.cal) cal_at = cyc;
      if (cal_at >= 0 && cyc == cal_at + 3) begin
        bus.start = 1;
        bus.cfg_wlen = 2;
      end
      if (cal_at >= 0 && cyc == cal_at + 4) bus.start = 0;
      if (cal_at >= 0 && cyc == cal_at + 6) bus.cal_done = 1;
      if (bus.wen) wen_cnt++;
      if (bus.r_valid && bus.r_ready) begin
        res_cnt++;
        bus.cal_done = 0;
      end
      if (bus.done) done_cnt++;
      step();
    end
    checks++;
    if (wen_cnt != 0 || res_cnt != 1 || done_cnt != 1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_start: wen=%0d results=%0d done=%0d busy=%b want 0 1 1 0", wen_cnt,
               res_cnt, done_cnt, bus.busy);
    end
    bus.cfg_wlen = 0; bus.cal_done = 1; done_cnt = 0; bus.start = 1;
    cal_at = -1;
    step();
    bus.start = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.cal) cal_at = cyc;
      if (bus.r_valid && rv_at < 0) begin
        rv_at = cyc;
        bus.cal_done = 0;
      end
      if (bus.done) done_cnt++;
      step();
    end
    checks++;
    if (cal_at < 0 || rv_at - cal_at != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL early_caldone: cal@%0d r_valid@%0d done=%0d want r_valid=cal+4 done=1",
               cal_at, rv_at, done_cnt);
    end
    bus.r_ready = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_start_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
